// File: rtl/e203_exu_wbck_sched_if.sv
// Write-back channel bundle: one request/response lane carrying a regfile write.
// The requester uses the master view and the consumer uses the slave view.
interface e203_exu_wbck_sched_if #(
    parameter int XLEN    = 32,
    parameter int RFIDX_W = 5
) ();
    logic               valid;
    logic               ready;
    logic [XLEN-1:0]    wdat;
    logic [RFIDX_W-1:0] rdidx;

    modport master (
        output valid,
        output wdat,
        output rdidx,
        input  ready
    );

    modport slave (
        input  valid,
        input  wdat,
        input  rdidx,
        output ready
    );
endinterface

// File: rtl/e203_exu_wbck_sched.sv
// Write-back scheduler: arbitrates ALU and long-pipe results onto the single
// regfile write port through a one-entry output stage, with ALU anti-starvation.
module e203_exu_wbck_sched #(
    parameter int XLEN         = 32,
    parameter int RFIDX_W      = 5,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    e203_exu_wbck_sched_if.slave          alu_wbck_i,
    e203_exu_wbck_sched_if.slave          longp_wbck_i,
    e203_exu_wbck_sched_if.master         rf_wbck_o,
    output logic                          oitf_ret_ena,
    output logic                          alu_starved
);

    localparam logic [CNT_W-1:0]   LIMIT_C  = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [RFIDX_W-1:0] RFIDX_X0 = {RFIDX_W{1'b0}};

    logic               rf_valid_q, rf_valid_d;
    logic [XLEN-1:0]    rf_wdat_q,  rf_wdat_d;
    logic [RFIDX_W-1:0] rf_rdidx_q, rf_rdidx_d;
    logic [CNT_W-1:0]   starve_cnt_q, starve_cnt_d;

    logic stage_free_s;
    logic starve_hit_s;
    logic grant_alu_s;
    logic grant_longp_s;
    logic alu_rdy_s;
    logic longp_rdy_s;
    logic alu_hs_s;
    logic longp_hs_s;

    // Arbitration: grants never look at the requester's own valid, so a lone
    // requester sees ready purely from stage availability.
    always_comb begin
        stage_free_s  = ~rf_valid_q | rf_wbck_o.ready;
        starve_hit_s  = (starve_cnt_q == LIMIT_C);
        grant_alu_s   = ~longp_wbck_i.valid | starve_hit_s;
        grant_longp_s = ~(alu_wbck_i.valid & starve_hit_s);
        // Nothing is accepted while reset is asserted, so no retire pulse leaks out.
        alu_rdy_s     = rst_n & stage_free_s & grant_alu_s;
        longp_rdy_s   = rst_n & stage_free_s & grant_longp_s;
        alu_hs_s      = alu_wbck_i.valid   & alu_rdy_s;
        longp_hs_s    = longp_wbck_i.valid & longp_rdy_s;
    end

    // Starvation counter: reset by an ALU win, bumped each time ALU waits and loses.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (alu_hs_s) begin
            starve_cnt_d = {CNT_W{1'b0}};
        end else if (alu_wbck_i.valid && longp_hs_s && !starve_hit_s) begin
            starve_cnt_d = starve_cnt_q + CNT_ONE;
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // Output stage: refill on the drain cycle; x0 writes are consumed but not staged.
    always_comb begin
        rf_valid_d = rf_valid_q;
        rf_wdat_d  = rf_wdat_q;
        rf_rdidx_d = rf_rdidx_q;
        if (stage_free_s) begin
            if (alu_hs_s && (alu_wbck_i.rdidx != RFIDX_X0)) begin
                rf_valid_d = 1'b1;
                rf_wdat_d  = alu_wbck_i.wdat;
                rf_rdidx_d = alu_wbck_i.rdidx;
            end else if (longp_hs_s && (longp_wbck_i.rdidx != RFIDX_X0)) begin
                rf_valid_d = 1'b1;
                rf_wdat_d  = longp_wbck_i.wdat;
                rf_rdidx_d = longp_wbck_i.rdidx;
            end else begin
                rf_valid_d = 1'b0;
            end
        end else begin
            rf_valid_d = rf_valid_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_valid_q   <= 1'b0;
            rf_wdat_q    <= {XLEN{1'b0}};
            rf_rdidx_q   <= RFIDX_X0;
            starve_cnt_q <= {CNT_W{1'b0}};
        end else begin
            rf_valid_q   <= rf_valid_d;
            rf_wdat_q    <= rf_wdat_d;
            rf_rdidx_q   <= rf_rdidx_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign alu_wbck_i.ready   = alu_rdy_s;
    assign longp_wbck_i.ready = longp_rdy_s;
    assign rf_wbck_o.valid    = rf_valid_q;
    assign rf_wbck_o.wdat     = rf_wdat_q;
    assign rf_wbck_o.rdidx    = rf_rdidx_q;
    assign oitf_ret_ena       = longp_hs_s;
    assign alu_starved        = starve_hit_s;

endmodule

// File: tb/tb_e203_exu_wbck_sched.sv
// Directed plus random bench for the write-back scheduler, checked against a
// queue-based model of pending regfile writes and a lost-arbitration count.
module tb_e203_exu_wbck_sched;
    localparam int XLEN    = 32;
    localparam int RFIDX_W = 5;
    localparam int LIMIT   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic oitf_ret_ena;
    logic alu_starved;

    e203_exu_wbck_sched_if #(.XLEN(XLEN), .RFIDX_W(RFIDX_W)) alu_if ();
    e203_exu_wbck_sched_if #(.XLEN(XLEN), .RFIDX_W(RFIDX_W)) longp_if ();
    e203_exu_wbck_sched_if #(.XLEN(XLEN), .RFIDX_W(RFIDX_W)) rf_if ();

    e203_exu_wbck_sched #(.XLEN(XLEN), .RFIDX_W(RFIDX_W), .STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_wbck_i   (alu_if),
        .longp_wbck_i (longp_if),
        .rf_wbck_o    (rf_if),
        .oitf_ret_ena (oitf_ret_ena),
        .alu_starved  (alu_starved)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0]    wdat;
        logic [RFIDX_W-1:0] rdidx;
    } wr_t;

    wr_t pend[$];
    int  lost;
    bit  known;
    int  total;
    int  bad;
    bit  saw_alu;
    bit  saw_longp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check against the model, then advance the model.
    task automatic cyc(input bit rst,
                       input bit av, input logic [XLEN-1:0] ad, input logic [RFIDX_W-1:0] ai,
                       input bit lv, input logic [XLEN-1:0] ld, input logic [RFIDX_W-1:0] li,
                       input bit rr);
        bit occ;
        bit free;
        bit hit;
        bit ea;
        bit el;
        rst_n          = ~rst;
        alu_if.valid   = av;
        alu_if.wdat    = ad;
        alu_if.rdidx   = ai;
        longp_if.valid = lv;
        longp_if.wdat  = ld;
        longp_if.rdidx = li;
        rf_if.ready    = rr;
        #1;
        occ  = (pend.size() != 0);
        free = !occ || rr;
        hit  = (lost == LIMIT);
        ea   = !rst && free && av && (!lv || hit);
        el   = !rst && free && lv && !(av && hit);
        if (av) chk("alu_ready", alu_if.ready, ea);
        if (lv) chk("longp_ready", longp_if.ready, el);
        chk("oitf_ret_ena", oitf_ret_ena, el);
        if (known) begin
            chk("rf_valid", rf_if.valid, occ);
            chk("alu_starved", alu_starved, hit);
            if (occ) begin
                chk("rf_wdat", rf_if.wdat, pend[0].wdat);
                chk("rf_rdidx", rf_if.rdidx, pend[0].rdidx);
            end
        end
        saw_alu   = alu_if.valid & alu_if.ready;
        saw_longp = longp_if.valid & longp_if.ready;
        @(posedge clk);
        if (rst) begin
            pend.delete();
            lost  = 0;
            known = 1'b1;
        end else begin
            if (occ && rr) void'(pend.pop_front());
            if (ea) begin
                lost = 0;
                if (ai != 0) pend.push_back(wr_t'{wdat: ad, rdidx: ai});
            end else if (el) begin
                if (av && lost < LIMIT) lost++;
                if (li != 0) pend.push_back(wr_t'{wdat: ld, rdidx: li});
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [9:0]         glog;
        int                 nl;
        bit                 r_rst;
        bit                 r_av;
        bit                 r_lv;
        bit                 r_rr;
        logic [XLEN-1:0]    r_ad;
        logic [XLEN-1:0]    r_ld;
        logic [RFIDX_W-1:0] r_ai;
        logic [RFIDX_W-1:0] r_li;
        total = 0;
        bad   = 0;
        lost  = 0;
        known = 1'b0;
        @(negedge clk);

        repeat (2) cyc(1'b1, 1'b1, 32'h0000_000A, 5'd1, 1'b1, 32'h0000_000B, 5'd2, 1'b1);

        cyc(1'b0, 1'b1, 32'h0000_1234, 5'd5, 1'b0, 32'h0, 5'd0, 1'b1);
        chk("single_alu_accept", saw_alu, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b1);

        glog = 10'd0;
        nl   = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b1, 32'h100 + 32'(i), 5'(i + 1), 1'b1, 32'h200 + 32'(i), 5'(i + 12), 1'b1);
            glog[i] = saw_alu;
            nl += int'(saw_longp);
        end
        chk("starve_pattern", glog, 10'b10_0001_0000);
        chk("starve_longp_count", nl, 8);

        repeat (3) cyc(1'b0, 1'b1, 32'h0000_AAAA, 5'd3, 1'b1, 32'h0000_BBBB, 5'd4, 1'b0);
        cyc(1'b0, 1'b1, 32'h0000_AAAA, 5'd3, 1'b1, 32'h0000_BBBB, 5'd4, 1'b1);
        chk("bp_longp_on_drain", saw_longp, 1'b1);

        cyc(1'b0, 1'b0, 32'h0, 5'd0, 1'b1, 32'h0000_FFFF, 5'd0, 1'b1);
        chk("x0_longp_accept", saw_longp, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b1);

        cyc(1'b0, 1'b1, 32'h0000_5555, 5'd7, 1'b0, 32'h0, 5'd0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 5'd0, 1'b1, 32'h0000_6666, 5'd8, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 5'd0, 1'b1, 32'h0000_6666, 5'd8, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            r_rst = ($urandom_range(0, 99) == 0);
            r_av  = ($urandom_range(0, 3) != 0);
            r_lv  = ($urandom_range(0, 3) != 0);
            r_rr  = ($urandom_range(0, 3) != 0);
            r_ad  = $urandom;
            r_ld  = $urandom;
            r_ai  = 5'($urandom_range(0, 31));
            r_li  = 5'($urandom_range(0, 31));
            cyc(r_rst, r_av, r_ad, r_ai, r_lv, r_ld, r_li, r_rr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
